// File: rtl/brush_stamper.sv
// brush_stamper: expands one stamp request into a row-major stream of single-pixel
// writes over a (2r+1)x(2r+1) square. Off-grid pixels are clipped; define BRUSH_WRAP_EN to wrap them instead.
module brush_stamper #(
   parameter int GRID_BITS = 6,
   parameter int RAD_BITS  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_stamp,
   input  logic [GRID_BITS-1:0] in_column,
   input  logic [GRID_BITS-1:0] in_row,
   input  logic [RAD_BITS-1:0]  in_radius,
   input  logic [7:0]           in_px_data,
   input  logic                 in_image_palette,
   input  logic                 in_image_overlay,
   input  logic                 in_write_available,
   output logic                 out_write,
   output logic [GRID_BITS-1:0] out_column,
   output logic [GRID_BITS-1:0] out_row,
   output logic [7:0]           out_px_data,
   output logic                 out_image_palette,
   output logic                 out_image_overlay,
   output logic                 out_busy,
   output logic                 out_done,
   output logic [1:0]           dbg_state
);
   localparam int DW = RAD_BITS + 1;
   localparam int TW = GRID_BITS + 2;

   // Handshake: a write is issued only on an edge where the FSM is in ISSUE and
   // in_write_available is 1; out_write then stays high for exactly one cycle and the
   // pixel coordinates hold until the next write. Encoding is visible on dbg_state.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [GRID_BITS-1:0] cx, cy, cx_nxt, cy_nxt;
   logic [RAD_BITS-1:0]  rad, rad_nxt;
   logic signed [DW-1:0] dx, dy, dx_nxt, dy_nxt;
   logic signed [DW-1:0] rad_s, dx_adv, dy_adv;
   logic signed [TW-1:0] tx, ty;
   logic                 off_grid, last;

   logic                 write_nxt, busy_nxt, done_nxt;
   logic [GRID_BITS-1:0] col_nxt, row_nxt;
   logic [7:0]           px_nxt;
   logic                 pal_nxt, ovl_nxt;

   assign rad_s = $signed({1'b0, rad});
   assign tx    = $signed({2'b00, cx}) + $signed({{(TW-DW){dx[DW-1]}}, dx});
   assign ty    = $signed({2'b00, cy}) + $signed({{(TW-DW){dy[DW-1]}}, dy});
   assign last  = (dx == rad_s) && (dy == rad_s);

`ifdef BRUSH_WRAP_EN
   assign off_grid = 1'b0;
`else
   // Targets span -3..66, so any set bit above the grid width means off-grid.
   assign off_grid = (|tx[TW-1:GRID_BITS]) | (|ty[TW-1:GRID_BITS]);
`endif

   always_comb begin
      if (dx == rad_s) begin
         dx_adv = -rad_s;
         dy_adv = dy + DW'(1);
      end else begin
         dx_adv = dx + DW'(1);
         dy_adv = dy;
      end
   end

   // State register plus all registered datapath and outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state             <= IDLE;
         cx                <= '0;
         cy                <= '0;
         rad               <= '0;
         dx                <= '0;
         dy                <= '0;
         out_write         <= 1'b0;
         out_column        <= '0;
         out_row           <= '0;
         out_px_data       <= '0;
         out_image_palette <= 1'b0;
         out_image_overlay <= 1'b0;
         out_busy          <= 1'b0;
         out_done          <= 1'b0;
      end else begin
         state             <= state_nxt;
         cx                <= cx_nxt;
         cy                <= cy_nxt;
         rad               <= rad_nxt;
         dx                <= dx_nxt;
         dy                <= dy_nxt;
         out_write         <= write_nxt;
         out_column        <= col_nxt;
         out_row           <= row_nxt;
         out_px_data       <= px_nxt;
         out_image_palette <= pal_nxt;
         out_image_overlay <= ovl_nxt;
         out_busy          <= busy_nxt;
         out_done          <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (in_stamp) state_nxt = ISSUE;
         ISSUE: begin
            if (off_grid) begin
               if (last) state_nxt = DONE;
            end else if (in_write_available) begin
               state_nxt = GAP;
            end
         end
         GAP:   state_nxt = last ? DONE : ISSUE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cx_nxt    = cx;
      cy_nxt    = cy;
      rad_nxt   = rad;
      dx_nxt    = dx;
      dy_nxt    = dy;
      write_nxt = out_write;
      col_nxt   = out_column;
      row_nxt   = out_row;
      px_nxt    = out_px_data;
      pal_nxt   = out_image_palette;
      ovl_nxt   = out_image_overlay;
      busy_nxt  = out_busy;
      done_nxt  = out_done;
      case (state)
         IDLE: begin
            if (in_stamp) begin
               cx_nxt   = in_column;
               cy_nxt   = in_row;
               rad_nxt  = in_radius;
               dx_nxt   = -$signed({1'b0, in_radius});
               dy_nxt   = -$signed({1'b0, in_radius});
               px_nxt   = in_px_data;
               pal_nxt  = in_image_palette;
               ovl_nxt  = in_image_overlay;
               busy_nxt = 1'b1;
            end
         end
         ISSUE: begin
            if (off_grid) begin
               dx_nxt = dx_adv;
               dy_nxt = dy_adv;
               if (last) done_nxt = 1'b1;
            end else if (in_write_available) begin
               write_nxt = 1'b1;
               col_nxt   = tx[GRID_BITS-1:0];
               row_nxt   = ty[GRID_BITS-1:0];
            end
         end
         GAP: begin
            write_nxt = 1'b0;
            dx_nxt    = dx_adv;
            dy_nxt    = dy_adv;
            if (last) done_nxt = 1'b1;
         end
         DONE: begin
            done_nxt = 1'b0;
            busy_nxt = 1'b0;
         end
         default: ;
      endcase
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_brush_stamper.sv
// tb_brush_stamper: randomized and directed stamps checked against a loop-based
// model of the square (clip or wrap follows BRUSH_WRAP_EN).
module tb_brush_stamper;
   localparam int GB = 6;
   localparam int RB = 2;
   localparam int W  = 22;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_stamp = 1'b0;
   logic [GB-1:0] in_column = '0;
   logic [GB-1:0] in_row = '0;
   logic [RB-1:0] in_radius = '0;
   logic [7:0]    in_px_data = '0;
   logic          in_image_palette = 1'b0;
   logic          in_image_overlay = 1'b0;
   logic          in_write_available = 1'b0;
   logic          out_write;
   logic [GB-1:0] out_column;
   logic [GB-1:0] out_row;
   logic [7:0]    out_px_data;
   logic          out_image_palette;
   logic          out_image_overlay;
   logic          out_busy;
   logic          out_done;
   logic [1:0]    dbg_state;

   brush_stamper #(.GRID_BITS(GB), .RAD_BITS(RB)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_stamp           (in_stamp),
      .in_column          (in_column),
      .in_row             (in_row),
      .in_radius          (in_radius),
      .in_px_data         (in_px_data),
      .in_image_palette   (in_image_palette),
      .in_image_overlay   (in_image_overlay),
      .in_write_available (in_write_available),
      .out_write          (out_write),
      .out_column         (out_column),
      .out_row            (out_row),
      .out_px_data        (out_px_data),
      .out_image_palette  (out_image_palette),
      .out_image_overlay  (out_image_overlay),
      .out_busy           (out_busy),
      .out_done           (out_done),
      .dbg_state          (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- scoreboard state ----------------
   int           total = 0;
   int           bad = 0;
   logic [W-1:0] exp_q[$];
   int           exp_n = 0;
   logic         exp_last_written = 1'b0;
   logic         pace_on = 1'b0;
   int           avail_mode = 0;   // 0: low, 1: high, 2: random
   int           cyc = 0;
   int           last_wr_cyc = 0;
   int           wr_in_stamp = 0;
   logic         have_last = 1'b0;
   logic         prev_write = 1'b0;
   logic         prev_done = 1'b0;

   wire [W-1:0]  pix_vec  = {out_column, out_row, out_px_data, out_image_palette, out_image_overlay};
   wire [24:0]   all_outs = {out_write, out_column, out_row, out_px_data, out_image_palette,
                             out_image_overlay, out_busy, out_done};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: enumerate the square row by row and keep what lands on the grid.
   task automatic build_expect(input int col, input int row, input int rad,
                               input logic [7:0] px, input logic pal, input logic ovl);
      exp_n = 0;
      for (int y = row - rad; y <= row + rad; y++) begin
         for (int x = col - rad; x <= col + rad; x++) begin
`ifdef BRUSH_WRAP_EN
            exp_q.push_back({6'(x & 63), 6'(y & 63), px, pal, ovl});
            exp_n++;
`else
            if (x >= 0 && x < 64 && y >= 0 && y < 64) begin
               exp_q.push_back({6'(x), 6'(y), px, pal, ovl});
               exp_n++;
            end
`endif
         end
      end
`ifdef BRUSH_WRAP_EN
      exp_last_written = 1'b1;
`else
      exp_last_written = (col + rad < 64) && (row + rad < 64);
`endif
   endtask

   // ---------------- availability driver ----------------
   always @(negedge clk) begin
      #1;
      case (avail_mode)
         0:       in_write_available = 1'b0;
         1:       in_write_available = 1'b1;
         default: in_write_available = ($urandom_range(0, 3) != 0);
      endcase
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         prev_write  = 1'b0;
         prev_done   = 1'b0;
         have_last   = 1'b0;
         wr_in_stamp = 0;
      end else begin
         if (prev_done) check_eq("busy_drop", {out_busy, out_done}, 0);
         if (out_write) begin
            check_eq("no_back_to_back", prev_write, 0);
            check_eq("busy_in_write", out_busy, 1);
            check_eq("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_eq("pixel", pix_vec, exp_q.pop_front());
            if (pace_on && have_last) check_eq("pace", cyc - last_wr_cyc, 2);
            have_last   = 1'b1;
            last_wr_cyc = cyc;
            wr_in_stamp++;
         end
         if (out_done) begin
            check_eq("done_q_empty", exp_q.size(), 0);
            check_eq("done_count", wr_in_stamp, exp_n);
            check_eq("done_busy", out_busy, 1);
            if (exp_last_written) check_eq("done_after_write", prev_write, 1);
            have_last   = 1'b0;
            wr_in_stamp = 0;
         end
         prev_write = out_write;
         prev_done  = out_done;
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge with the block idle; returns at a negedge after capture.
   task automatic start_stamp(input int col, input int row, input int rad,
                              input logic [7:0] px, input logic pal, input logic ovl,
                              input logic noise);
      build_expect(col, row, rad, px, pal, ovl);
      in_column        = 6'(col);
      in_row           = 6'(row);
      in_radius        = 2'(rad);
      in_px_data       = px;
      in_image_palette = pal;
      in_image_overlay = ovl;
      in_stamp         = 1'b1;
      @(negedge clk);
      if (noise) begin
         in_column  = 6'd40;
         in_row     = 6'd40;
         in_radius  = 2'd3;
         in_px_data = 8'($urandom);
         @(negedge clk);
         @(negedge clk);
      end
      in_stamp         = 1'b0;
      in_column        = 6'($urandom);
      in_row           = 6'($urandom);
      in_radius        = 2'($urandom);
      in_px_data       = 8'($urandom);
      in_image_palette = 1'($urandom);
      in_image_overlay = 1'($urandom);
   endtask

   // Waits for out_done, then one more cycle so busy is low on return.
   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!out_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("done_seen", out_done, 1);
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int k;
      int c;
      int r;
      int rd;

      repeat (3) @(negedge clk);
      check_eq("reset_outs", all_outs, 0);
      check_eq("reset_state", dbg_state, 0);
      #2 rst = 1'b1;
      avail_mode = 1;
      @(negedge clk);
      @(negedge clk);

      // radius 0: exact cycle timing
      start_stamp(13, 32, 0, 8'hF2, 1'b1, 1'b0, 1'b0);
      check_eq("r0_busy", {out_busy, out_write}, 2'b10);
      @(negedge clk);
      check_eq("r0_write", {out_write, out_column, out_row, out_px_data}, {1'b1, 6'd13, 6'd32, 8'hF2});
      @(negedge clk);
      check_eq("r0_done", {out_done, out_write, out_busy}, 3'b101);
      @(negedge clk);
      check_eq("r0_idle", {out_busy, out_done, dbg_state}, 0);

      // radius 1 at (10,10), unstalled pacing
      pace_on = 1'b1;
      start_stamp(10, 10, 1, 8'h3C, 1'b0, 1'b1, 1'b0);
      wait_done(200);
      pace_on = 1'b0;

      // corner (0,0): clipped or wrapped
      start_stamp(0, 0, 1, 8'h11, 1'b1, 1'b1, 1'b0);
      wait_done(200);

      // stall after the third write
      start_stamp(10, 10, 1, 8'h77, 1'b0, 1'b0, 1'b0);
      n = 0;
      k = 0;
      while (n < 3 && k < 50) begin
         @(negedge clk);
         k++;
         if (out_write) n++;
      end
      check_eq("stall_reach3", n, 3);
      avail_mode = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("stall_hold", {out_write, out_column, out_row}, {1'b0, 6'd11, 6'd9});
      end
      avail_mode = 1;
      wait_done(200);

      // stamp request while busy is ignored
      avail_mode = 2;
      start_stamp(20, 20, 2, 8'hA5, 1'b1, 1'b0, 1'b1);
      wait_done(1000);
      @(negedge clk);
      check_eq("noise_idle", {dbg_state, out_busy}, 0);

      // reset mid-stamp
      avail_mode = 1;
      start_stamp(30, 30, 3, 8'h5C, 1'b1, 1'b1, 1'b0);
      repeat (6) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_eq("async_reset_outs", all_outs, 0);
      check_eq("async_reset_state", dbg_state, 0);
      exp_q.delete();
      @(negedge clk);
      check_eq("reset_hold", all_outs, 0);
      #2 rst = 1'b1;
      @(negedge clk);
      check_eq("post_reset_idle", {dbg_state, out_busy}, 0);
      start_stamp(5, 5, 1, 8'h42, 1'b0, 1'b1, 1'b0);
      wait_done(200);

      // radius 3 in the far corner
      start_stamp(63, 63, 3, 8'hC3, 1'b1, 1'b0, 1'b0);
      wait_done(1000);

      // randomized stamps, biased toward the grid edges
      for (int i = 0; i < 14; i++) begin
         c  = ($urandom_range(0, 2) == 0) ?
              (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(61, 63)))
              : int'($urandom_range(0, 63));
         r  = ($urandom_range(0, 2) == 0) ?
              (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : int'($urandom_range(61, 63)))
              : int'($urandom_range(0, 63));
         rd = int'($urandom_range(0, 3));
         avail_mode = int'($urandom_range(1, 2));
         start_stamp(c, r, rd, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
         wait_done(1000);
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
